// File: rtl/vga_timing_core.sv
// vga_timing_core: parametrised VGA raster engine. A clock divider produces a
// one-cycle pixel enable; stage-0 h/v counters generate coordinates and sync
// decode, which then travel through a PIX_LAT+1 deep alignment pipeline so that
// HS/VS/BLANK_N line up with the RGB sampled from the external renderer.
module vga_timing_core #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CLK_DIV  = 2,
  parameter int PIX_LAT  = 1,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [23:0]      pixel_rgb,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             pixel_req,
  output logic             pix_tick,
  output logic             line_start,
  output logic             frame_start,
  output logic             VGA_CLK,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             VGA_BLANK_N,
  output logic [7:0]       VGA_R,
  output logic [7:0]       VGA_G,
  output logic [7:0]       VGA_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Decode thresholds are one bit wider than the counters so that a sync
  // window ending exactly at 2^CNT_W still compares correctly.
  localparam logic [CNT_W:0] H_ACT_C  = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0] H_SBEG_C = (CNT_W+1)'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0] H_SEND_C = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0] V_ACT_C  = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0] V_SBEG_C = (CNT_W+1)'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0] V_SEND_C = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [3:0]       DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [4:0]       DIV_HALF = 5'(CLK_DIV / 2);
  localparam logic             HS_ACT = (HS_POL != 0);
  localparam logic             VS_ACT = (VS_POL != 0);

  // Pipeline word layout: {hs, vs, active}
  localparam int B_HS  = 2;
  localparam int B_VS  = 1;
  localparam int B_ACT = 0;

  logic [3:0]       div_cnt_q, div_cnt_d;
  logic             vga_clk_q, vga_clk_d;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic [CNT_W:0]   h_ext, v_ext;
  logic [2:0]       stage0;
  logic [2:0]       align;
  logic [2:0]       pipe_src [PIX_LAT+1];
  logic [2:0]       pipe_d   [PIX_LAT+1];
  logic [2:0]       pipe_q   [PIX_LAT+1];
  logic [23:0]      rgb_d, rgb_q;

  // Pixel enable is suppressed while reset is held so no stray line/frame
  // pulses reach the renderer during reset.
  assign pix_tick    = !reset && (div_cnt_q == DIV_LAST);
  assign line_start  = pix_tick && (h_q == '0);
  assign frame_start = pix_tick && (h_q == '0) && (v_q == '0);

  // Divider, divided DAC clock and stage-0 raster counters
  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? 4'd0 : div_cnt_q + 4'd1;
    vga_clk_d = ({1'b0, div_cnt_q} + 5'd1) > DIV_HALF;
    h_d = h_q;
    v_d = v_q;
    if (pix_tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Stage 0: decode position into {hs, vs, active}
  always_comb begin
    h_ext = {1'b0, h_q};
    v_ext = {1'b0, v_q};
    stage0        = '0;
    stage0[B_ACT] = (h_ext < H_ACT_C) && (v_ext < V_ACT_C);
    stage0[B_HS]  = (h_ext >= H_SBEG_C) && (h_ext < H_SEND_C);
    stage0[B_VS]  = (v_ext >= V_SBEG_C) && (v_ext < V_SEND_C);
  end

  // Stages 1..PIX_LAT+1: alignment shift register and RGB capture; the word
  // entering the last stage is the one whose pixel_rgb arrives on this tick
  always_comb begin
    pipe_src[0] = stage0;
    for (int i = 1; i <= PIX_LAT; i++) pipe_src[i] = pipe_q[i-1];
    for (int i = 0; i <= PIX_LAT; i++) pipe_d[i] = pix_tick ? pipe_src[i] : pipe_q[i];
    align = pipe_src[PIX_LAT];
    rgb_d = rgb_q;
    if (pix_tick) rgb_d = align[B_ACT] ? pixel_rgb : 24'h000000;
  end

  // State registers; reset flushes the pipeline to blank, inactive sync
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      vga_clk_q <= 1'b0;
      h_q       <= '0;
      v_q       <= '0;
      rgb_q     <= '0;
      for (int i = 0; i <= PIX_LAT; i++) pipe_q[i] <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      vga_clk_q <= vga_clk_d;
      h_q       <= h_d;
      v_q       <= v_d;
      rgb_q     <= rgb_d;
      for (int i = 0; i <= PIX_LAT; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign x           = h_q;
  assign y           = v_q;
  assign pixel_req   = stage0[B_ACT];
  assign VGA_CLK     = vga_clk_q;
  assign VGA_HS      = pipe_q[PIX_LAT][B_HS] ? HS_ACT : !HS_ACT;
  assign VGA_VS      = pipe_q[PIX_LAT][B_VS] ? VS_ACT : !VS_ACT;
  assign VGA_BLANK_N = pipe_q[PIX_LAT][B_ACT];
  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];

endmodule
